// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for one pipeline boundary register.
// slave = the stage register itself, master = the surrounding logic that feeds and drains it.
interface pipe_stage_reg_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_rfwe;
    logic [DATA_W-1:0] in_rfwd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_rfwe;
    logic [DATA_W-1:0] out_rfwd;
    logic [1:0]        occ;

    modport slave (
        input  in_valid, in_pc, in_inst, in_rfwe, in_rfwd, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rfwe, out_rfwd, occ
    );

    modport master (
        output in_valid, in_pc, in_inst, in_rfwe, in_rfwd, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rfwe, out_rfwd, occ
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register (IF/ID .. MEM/WB) with valid/ready handshake, flush and
// an optional second (skid) entry so in_ready can be registered without losing throughput.
module pipe_stage_reg #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter bit                 SKID     = 1'b1,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_stage_reg_if.slave s
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;

    logic [PC_W-1:0]   main_pc_p0;
    logic [INST_W-1:0] main_inst_p0;
    logic              main_rfwe_p0;
    logic [DATA_W-1:0] main_rfwd_p0;

    logic [PC_W-1:0]   skid_pc_p0;
    logic [INST_W-1:0] skid_inst_p0;
    logic              skid_rfwe_p0;
    logic [DATA_W-1:0] skid_rfwd_p0;

    logic vld_p0;
    logic accept;
    logic drain;

    assign vld_p0 = (state != EMPTY);
    assign accept = s.in_valid & s.in_ready;
    assign drain  = vld_p0 & s.out_ready;

    // SKID=1: in_ready decodes only the state register, cutting the out_ready->in_ready path.
    generate
        if (SKID) begin : g_skid
            assign s.in_ready = (state != TWO);
        end else begin : g_noskid
            assign s.in_ready = s.out_ready | ~vld_p0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            main_pc_p0   <= '0;
            main_inst_p0 <= NOP_INST;
            main_rfwe_p0 <= 1'b0;
            main_rfwd_p0 <= '0;
            skid_pc_p0   <= '0;
            skid_inst_p0 <= NOP_INST;
            skid_rfwe_p0 <= 1'b0;
            skid_rfwd_p0 <= '0;
        end else if (s.flush) begin
            // flush beats any accept in the same cycle
            state        <= EMPTY;
            main_pc_p0   <= '0;
            main_inst_p0 <= NOP_INST;
            main_rfwe_p0 <= 1'b0;
            main_rfwd_p0 <= '0;
            skid_pc_p0   <= '0;
            skid_inst_p0 <= NOP_INST;
            skid_rfwe_p0 <= 1'b0;
            skid_rfwd_p0 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state        <= ONE;
                        main_pc_p0   <= s.in_pc;
                        main_inst_p0 <= s.in_inst;
                        main_rfwe_p0 <= s.in_rfwe;
                        main_rfwd_p0 <= s.in_rfwd;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_pc_p0   <= s.in_pc;
                        main_inst_p0 <= s.in_inst;
                        main_rfwe_p0 <= s.in_rfwe;
                        main_rfwd_p0 <= s.in_rfwd;
                    end else if (accept) begin
                        state        <= TWO;
                        skid_pc_p0   <= s.in_pc;
                        skid_inst_p0 <= s.in_inst;
                        skid_rfwe_p0 <= s.in_rfwe;
                        skid_rfwd_p0 <= s.in_rfwd;
                    end else if (drain) begin
                        // pc/rfwd keep the last drained beat; inst/rfwe fall back to a bubble
                        state        <= EMPTY;
                        main_inst_p0 <= NOP_INST;
                        main_rfwe_p0 <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state        <= ONE;
                        main_pc_p0   <= skid_pc_p0;
                        main_inst_p0 <= skid_inst_p0;
                        main_rfwe_p0 <= skid_rfwe_p0;
                        main_rfwd_p0 <= skid_rfwd_p0;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Output stage: main entry drives the boundary directly.
    assign s.out_valid = vld_p0;
    assign s.out_pc    = main_pc_p0;
    assign s.out_inst  = main_inst_p0;
    assign s.out_rfwe  = main_rfwe_p0;
    assign s.out_rfwd  = main_rfwd_p0;
    assign s.occ       = state;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance on a shared clock/reset.
module tb_pipe_stage_reg;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.PC_W(32), .INST_W(32), .DATA_W(32)) if1 ();
    pipe_stage_reg_if #(.PC_W(32), .INST_W(32), .DATA_W(32)) if0 ();

    pipe_stage_reg #(.PC_W(32), .INST_W(32), .DATA_W(32), .SKID(1'b1), .NOP_INST(NOP)) u_dut_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (if1)
    );

    pipe_stage_reg #(.PC_W(32), .INST_W(32), .DATA_W(32), .SKID(1'b0), .NOP_INST(NOP)) u_dut_noskid (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (if0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic [31:0] wd);
        if1.in_valid = v;
        if1.in_pc    = pc;
        if1.in_inst  = 32'h00100093 ^ pc;
        if1.in_rfwe  = 1'b1;
        if1.in_rfwd  = wd;
    endtask

    initial begin
        drive1(1'b0, 32'h0, 32'h0);
        if1.flush = 1'b0; if1.out_ready = 1'b0;
        if0.in_valid = 1'b0; if0.in_pc = '0; if0.in_inst = '0; if0.in_rfwe = 1'b0;
        if0.in_rfwd = '0; if0.flush = 1'b0; if0.out_ready = 1'b0;

        // reset / idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_valid", if1.out_valid, 0);
        chk("rst_inst",  if1.out_inst, NOP);
        chk("rst_rfwe",  if1.out_rfwe, 0);
        chk("rst_occ",   if1.occ, 0);
        chk("rst_ready", if1.in_ready, 1);
        chk("rst_pc",    if1.out_pc, 0);
        chk("rst_rfwd",  if1.out_rfwd, 0);
        chk("rst0_ready", if0.in_ready, 1);

        // streaming: one beat per cycle, one cycle latency
        if1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive1(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1));
            tick();
            chk("stream_valid", if1.out_valid, 1);
            chk("stream_pc",    if1.out_pc, 32'h100 + 32'(4 * i));
            chk("stream_rfwd",  if1.out_rfwd, 32'(i + 1));
            chk("stream_inst",  if1.out_inst, 32'h00100093 ^ (32'h100 + 32'(4 * i)));
            chk("stream_occ",   if1.occ, 1);
        end
        drive1(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_valid", if1.out_valid, 0);
        chk("drain_inst",  if1.out_inst, NOP);
        chk("drain_rfwe",  if1.out_rfwe, 0);
        chk("drain_pc_hold", if1.out_pc, 32'h108);

        // backpressure into the skid entry
        if1.out_ready = 1'b0;
        drive1(1'b1, 32'h200, 32'h20);
        tick();
        chk("bp_occ1", if1.occ, 1);
        chk("bp_rdy1", if1.in_ready, 1);
        drive1(1'b1, 32'h204, 32'h24);
        tick();
        chk("bp_occ2", if1.occ, 2);
        chk("bp_rdy0", if1.in_ready, 0);
        chk("bp_pc_a", if1.out_pc, 32'h200);
        drive1(1'b1, 32'h208, 32'h28);
        tick();
        chk("bp_hold_occ", if1.occ, 2);
        chk("bp_hold_pc",  if1.out_pc, 32'h200);
        chk("bp_hold_wd",  if1.out_rfwd, 32'h20);
        if1.out_ready = 1'b1;
        #1;
        chk("bp_rdy_registered", if1.in_ready, 0);
        tick();
        chk("bp_out2_pc", if1.out_pc, 32'h204);
        chk("bp_out2_wd", if1.out_rfwd, 32'h24);
        chk("bp_out2_occ", if1.occ, 1);
        tick();
        chk("bp_out3_pc", if1.out_pc, 32'h208);
        chk("bp_out3_occ", if1.occ, 1);
        drive1(1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_empty", if1.out_valid, 0);

        // flush with a full stage
        if1.out_ready = 1'b0;
        drive1(1'b1, 32'h280, 32'h5);
        tick();
        drive1(1'b1, 32'h284, 32'h6);
        tick();
        chk("fl_occ2", if1.occ, 2);
        drive1(1'b1, 32'h300, 32'h7);
        if1.flush = 1'b1;
        tick();
        if1.flush = 1'b0;
        drive1(1'b0, 32'h0, 32'h0);
        chk("fl_occ",   if1.occ, 0);
        chk("fl_valid", if1.out_valid, 0);
        chk("fl_rfwe",  if1.out_rfwe, 0);
        chk("fl_inst",  if1.out_inst, NOP);
        chk("fl_pc",    if1.out_pc, 0);
        chk("fl_rfwd",  if1.out_rfwd, 0);
        chk("fl_ready", if1.in_ready, 1);

        // flush wins over an accept into an empty stage
        drive1(1'b1, 32'h300, 32'h7);
        if1.flush = 1'b1;
        tick();
        if1.flush = 1'b0;
        drive1(1'b0, 32'h0, 32'h0);
        chk("fla_valid", if1.out_valid, 0);
        tick();
        chk("fla_valid2", if1.out_valid, 0);
        chk("fla_pc", if1.out_pc, 0);

        // asynchronous reset while stalled at occ=2
        drive1(1'b1, 32'h400, 32'h40);
        tick();
        drive1(1'b1, 32'h404, 32'h44);
        tick();
        drive1(1'b0, 32'h0, 32'h0);
        chk("ar_occ2", if1.occ, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", if1.out_valid, 0);
        chk("ar_occ",   if1.occ, 0);
        chk("ar_pc",    if1.out_pc, 0);
        chk("ar_inst",  if1.out_inst, NOP);
        chk("ar_rfwd",  if1.out_rfwd, 0);
        tick();
        rst_n = 1'b1;
        if1.out_ready = 1'b1;
        tick();
        tick();
        chk("ar_nobeat", if1.out_valid, 0);
        chk("ar_ready", if1.in_ready, 1);

        // SKID=0 instance: combinational in_ready
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b1; if0.in_pc = 32'h500; if0.in_inst = 32'hA; if0.in_rfwe = 1'b1; if0.in_rfwd = 32'h50;
        #1;
        chk("ns_rdy_empty", if0.in_ready, 1);
        tick();
        chk("ns_valid", if0.out_valid, 1);
        chk("ns_rdy_stall", if0.in_ready, 0);
        chk("ns_occ1", if0.occ, 1);
        if0.in_pc = 32'h504; if0.in_rfwd = 32'h54;
        tick();
        chk("ns_stall_pc", if0.out_pc, 32'h500);
        chk("ns_stall_occ", if0.occ, 1);
        if0.out_ready = 1'b1;
        #1;
        chk("ns_rdy_comb", if0.in_ready, 1);
        tick();
        chk("ns_pc504", if0.out_pc, 32'h504);
        chk("ns_occ_a", if0.occ, 1);
        if0.in_pc = 32'h508; if0.in_rfwd = 32'h58;
        tick();
        chk("ns_pc508", if0.out_pc, 32'h508);
        chk("ns_wd508", if0.out_rfwd, 32'h58);
        chk("ns_occ_b", if0.occ, 1);
        if0.in_valid = 1'b0;
        tick();
        chk("ns_empty", if0.out_valid, 0);
        chk("ns_occ0", if0.occ, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
